loteria_input_conditioner: RTL and testbench
============================================

# loteria_input_conditioner

Front-end stage for the lottery FSM. Converts the raw board pushbuttons (active-low KEYs) and the 4-bit digit switches into clean, synchronized, single-cycle `insert_pulse`/`finish_pulse` strobes with a stable, validated `num_out`. It exists because the lottery FSM samples `insert` and `finish` as levels every clock: a held or bouncing key would otherwise consume several digits. Instantiated between the board pins and the lottery FSM `insert`/`finish`/`num` inputs.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable cycles required to accept a press or a release (20 ms at 50 MHz). Must be ≥ 2.
- `CNT_W`, $clog2(DEBOUNCE_CYCLES+1): debounce counter width.

- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `key_insert_n`  in  1  raw insert button, asynchronous, low = pressed.
- `key_finish_n`  in  1  raw finish button, asynchronous, low = pressed.
- `sw_num`  in  4  raw digit switches, asynchronous.
- `insert_pulse`  out  1  one-cycle strobe: valid digit accepted.
- `finish_pulse`  out  1  one-cycle strobe: finish accepted.
- `num_out`  out  4  last accepted digit, 0–9, held stable between strobes.
- `num_invalid`  out  1  sticky flag: last insert attempt had `sw_num` > 9.

## Operation
- Every async input passes through a 2-FF synchronizer. Key synchronizers reset to 1 (released). Switch synchronizers reset to 0.
- Each key has its own debounce FSM: ARMING, IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - ARMING is entered on reset. The counter counts consecutive released samples; reaching `DEBOUNCE_CYCLES` moves to IDLE. A pressed sample clears the counter. A key held through reset therefore never produces a pulse until it has been released.
  - IDLE: a pressed sample moves to PRESS_WAIT with count = 1.
  - PRESS_WAIT: each pressed sample increments the count. A released sample returns to IDLE with count = 0. When the count reaches `DEBOUNCE_CYCLES`, the FSM goes to PRESSED and raises a `qualify` strobe for 1 cycle.
  - PRESSED: a released sample moves to RELEASE_WAIT with count = 1.
  - RELEASE_WAIT: each released sample increments the count; a pressed sample returns to PRESSED. When the count reaches `DEBOUNCE_CYCLES`, the FSM goes to IDLE. No strobe is generated on release.
- Insert qualify:
  - If the synchronized `sw_num` is ≤ 9: latch it into `num_out`, assert `insert_pulse`, clear `num_invalid`.
  - If it is > 9: no pulse, `num_out` unchanged, set `num_invalid`.
- Finish qualify asserts `finish_pulse`.
- Simultaneous qualifies in the same cycle: insert is issued first. The finish strobe is held in a 1-bit pending register and issued the following cycle. `insert_pulse` and `finish_pulse` are never high together.
- Auto-repeat is not supported: one press gives at most one strobe.

## Timing
- Reset values:
  - `insert_pulse` = 0, `finish_pulse` = 0, `num_out` = 0, `num_invalid` = 0.
  - Both FSMs in ARMING, counters 0, finish pending = 0.
- Reset mid-operation: all state returns to the reset values on the next edge. A pending finish strobe is discarded.
- Latency: let edge k be the first edge at which `key_*_n` is sampled low into FF1, and assume the key stays low. The strobe is registered at edge k+1+D, where D = `DEBOUNCE_CYCLES`, and is high for exactly one cycle. A deferred finish strobe appears one edge later.
- `num_out` changes only on the same edge that raises `insert_pulse`. It is valid in the cycle the pulse is high and afterwards.
- The `sw_num` value used is the synchronized value at the qualify edge. Switches must be stable for ≥ 2 cycles beforehand.

## Structure
- Shared package `loteria_pkg`:
  - `DIGIT_MAX = 4'd9`.
  - Enum `deb_state_t` with values ARMING, IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
  - Digit type `digit_t` (logic [3:0]).
- Sub-module `debounce_onepulse`: synchronizer, debounce FSM and qualify strobe for one key, parameterized by `DEBOUNCE_CYCLES`. It is instantiated twice. The top level adds the switch synchronizer, digit validation, `num_invalid` and the insert/finish arbitration.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4.
- Clean press: `sw_num`=5 held, `key_insert_n` low from edge 10 → `insert_pulse` high only in the cycle after edge 15; `num_out`=5; no second pulse while the key is held for 50 cycles.
- Bounce: `key_insert_n` toggles 1-0-1-0-0-1 before a steady low → exactly one `insert_pulse`, 5 cycles after the start of the steady low.
- Invalid digit: `sw_num`=12, clean insert press → no pulse, `num_invalid`=1, `num_out` keeps its prior value 5. Then `sw_num`=9 and press → pulse, `num_out`=9, `num_invalid`=0.
- Simultaneous: both keys go low on the same edge → `insert_pulse` in cycle c, `finish_pulse` in cycle c+1, never overlapping.
- Held through reset: key low during and after `reset` deasserts → no strobe. After release for ≥4 cycles and a new press → one strobe.
- Reset mid-PRESS_WAIT (key low for 2 cycles, then `reset` pulsed) → all outputs 0, no strobe, ARMING re-entered.

Source files
------------

// File: rtl/loteria_pkg.sv
// Shared types and constants for the lottery front-end and FSM.
// Digit range limit, debounce state encoding and the digit type.
package loteria_pkg;

    localparam logic [3:0] DIGIT_MAX = 4'd9;

    typedef logic [3:0] digit_t;

    typedef enum logic [2:0] {
        ARMING,
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_t;

    function automatic logic digit_valid(input digit_t d);
        return d <= DIGIT_MAX;
    endfunction

endpackage

// File: rtl/loteria_input_conditioner_debounce.sv
// One active-low key: 2-FF synchronizer, debounce FSM and a single-cycle
// qualify strobe asserted in the cycle the press is accepted.
module debounce_onepulse
    import loteria_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic qualify
);

    localparam logic [CNT_W-1:0] TARGET = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic             key_s1;
    logic             key_s2;
    logic             pressed;
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic [CNT_W-1:0] cnt_inc;

    // Synchronizer idles at "released" so reset never looks like a press.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= key_n;
            key_s2 <= key_s1;
        end
    end

    assign pressed = ~key_s2;
    assign cnt_inc = cnt + ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ARMING;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        qualify    = 1'b0;
        case (state)
            ARMING: begin
                if (pressed) begin
                    cnt_next = '0;
                end else if (cnt_inc == TARGET) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            IDLE: begin
                if (pressed) begin
                    state_next = PRESS_WAIT;
                    cnt_next   = ONE;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt_inc == TARGET) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                    qualify    = 1'b1;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            PRESSED: begin
                if (!pressed) begin
                    state_next = RELEASE_WAIT;
                    cnt_next   = ONE;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_next = PRESSED;
                    cnt_next   = '0;
                end else if (cnt_inc == TARGET) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = ARMING;
                cnt_next   = '0;
            end
        endcase
    end

endmodule

// File: rtl/loteria_input_conditioner.sv
// Board-pin front end for the lottery FSM: debounced single-cycle insert/finish
// strobes, validated digit latch and insert-before-finish arbitration.
module loteria_input_conditioner
    import loteria_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_insert_n,
    input  logic       key_finish_n,
    input  logic [3:0] sw_num,
    output logic       insert_pulse,
    output logic       finish_pulse,
    output logic [3:0] num_out,
    output logic       num_invalid
);

    digit_t sw_s1;
    digit_t sw_s2;
    logic   insert_q;
    logic   finish_q;
    logic   insert_fire;
    logic   finish_pending;

    debounce_onepulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_insert (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_insert_n),
        .qualify(insert_q)
    );

    debounce_onepulse #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_deb_finish (
        .clk    (clk),
        .reset  (reset),
        .key_n  (key_finish_n),
        .qualify(finish_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            sw_s1 <= '0;
            sw_s2 <= '0;
        end else begin
            sw_s1 <= sw_num;
            sw_s2 <= sw_s1;
        end
    end

    assign insert_fire = insert_q && digit_valid(sw_s2);

    // A finish qualifying alongside an issued insert is deferred one cycle;
    // debounce spacing guarantees nothing else can collide with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            insert_pulse   <= 1'b0;
            finish_pulse   <= 1'b0;
            finish_pending <= 1'b0;
            num_out        <= '0;
            num_invalid    <= 1'b0;
        end else begin
            insert_pulse   <= insert_fire;
            finish_pulse   <= finish_pending || (finish_q && !insert_fire);
            finish_pending <= finish_q && insert_fire;
            if (insert_fire) begin
                num_out <= sw_s2;
            end
            if (insert_q) begin
                num_invalid <= !digit_valid(sw_s2);
            end
        end
    end

endmodule

// File: tb/tb_loteria_input_conditioner.sv
// Self-checking bench: directed scenarios with fixed expectations plus
// randomized key/switch activity compared against a run-length reference model.
module tb_loteria_input_conditioner;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_insert_n = 1'b1;
    logic       key_finish_n = 1'b1;
    logic [3:0] sw_num = 4'd0;
    logic       insert_pulse;
    logic       finish_pulse;
    logic [3:0] num_out;
    logic       num_invalid;

    int checks = 0;
    int failures = 0;
    int overlap = 0;

    loteria_input_conditioner #(
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_insert_n(key_insert_n),
        .key_finish_n(key_finish_n),
        .sw_num      (sw_num),
        .insert_pulse(insert_pulse),
        .finish_pulse(finish_pulse),
        .num_out     (num_out),
        .num_invalid (num_invalid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (insert_pulse && finish_pulse) overlap++;

    // Reference model: each key has an accepted level ("held", pressed after
    // reset) and a run of consecutive opposite samples; D of them flip it.
    logic       m_i1, m_i2, m_f1, m_f2;
    logic [3:0] m_sw1, m_sw2;
    bit         m_ih, m_fh;
    int         m_ir, m_fr;
    bit         exp_ins, exp_fin, exp_pend, exp_inv;
    logic [3:0] exp_num;
    bit         m_ip, m_fp, m_iq, m_fq, m_fire;

    always_comb begin
        m_ip   = !m_i2;
        m_fp   = !m_f2;
        m_iq   = m_ip && !m_ih && (m_ir + 1 >= D);
        m_fq   = m_fp && !m_fh && (m_fr + 1 >= D);
        m_fire = m_iq && (m_sw2 <= 4'd9);
    end

    always @(posedge clk) begin
        if (reset) begin
            m_i1 <= 1'b1; m_i2 <= 1'b1; m_f1 <= 1'b1; m_f2 <= 1'b1;
            m_sw1 <= 4'd0; m_sw2 <= 4'd0;
            m_ih <= 1'b1; m_fh <= 1'b1; m_ir <= 0; m_fr <= 0;
            exp_ins <= 1'b0; exp_fin <= 1'b0; exp_pend <= 1'b0;
            exp_inv <= 1'b0; exp_num <= 4'd0;
        end else begin
            m_i1 <= key_insert_n; m_i2 <= m_i1;
            m_f1 <= key_finish_n; m_f2 <= m_f1;
            m_sw1 <= sw_num; m_sw2 <= m_sw1;
            if (m_ip != m_ih) begin
                if (m_ir + 1 >= D) begin m_ih <= m_ip; m_ir <= 0; end
                else m_ir <= m_ir + 1;
            end else m_ir <= 0;
            if (m_fp != m_fh) begin
                if (m_fr + 1 >= D) begin m_fh <= m_fp; m_fr <= 0; end
                else m_fr <= m_fr + 1;
            end else m_fr <= 0;
            exp_ins  <= m_fire;
            exp_fin  <= exp_pend || (m_fq && !m_fire);
            exp_pend <= m_fq && m_fire;
            if (m_fire) exp_num <= m_sw2;
            if (m_iq) exp_inv <= (m_sw2 > 4'd9);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Tick n=1 is the first edge that samples the key low.
    task automatic press_keys(input bit ins, input bit fin, input int hold,
                              output int n_ins, output int n_fin,
                              output int t_ins, output int t_fin);
        n_ins = 0; n_fin = 0; t_ins = -1; t_fin = -1;
        if (ins) key_insert_n = 1'b0;
        if (fin) key_finish_n = 1'b0;
        for (int n = 1; n <= hold + D + 6; n++) begin
            if (n == hold + 1) begin
                key_insert_n = 1'b1;
                key_finish_n = 1'b1;
            end
            tick();
            if (insert_pulse) begin n_ins++; if (t_ins < 0) t_ins = n; end
            if (finish_pulse) begin n_fin++; if (t_fin < 0) t_fin = n; end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; key_insert_n = 1'b0; sw_num = 4'd7;
        tick(); tick();
        checks++; if (insert_pulse !== 1'b0) begin failures++; $display("FAIL reset_insert: got %b expected 0", insert_pulse); end
        checks++; if (finish_pulse !== 1'b0) begin failures++; $display("FAIL reset_finish: got %b expected 0", finish_pulse); end
        checks++; if (num_out !== 4'd0) begin failures++; $display("FAIL reset_num: got %0d expected 0", num_out); end
        checks++; if (num_invalid !== 1'b0) begin failures++; $display("FAIL reset_invalid: got %b expected 0", num_invalid); end
        key_insert_n = 1'b1; sw_num = 4'd0;
        reset = 1'b0;
        repeat (D + 4) tick();
    endtask

    task automatic test_clean_press();
        int ni, nf, ti, tf;
        sw_num = 4'd5; tick(); tick();
        press_keys(1'b1, 1'b0, 50, ni, nf, ti, tf);
        checks++; if (ti !== D + 2) begin failures++; $display("FAIL clean_latency: got %0d expected %0d", ti, D + 2); end
        checks++; if (ni !== 1) begin failures++; $display("FAIL clean_count: got %0d expected 1", ni); end
        checks++; if (nf !== 0) begin failures++; $display("FAIL clean_no_finish: got %0d expected 0", nf); end
        checks++; if (num_out !== 4'd5) begin failures++; $display("FAIL clean_num: got %0d expected 5", num_out); end
    endtask

    task automatic test_bounce();
        bit pattern [6] = '{1, 0, 1, 0, 0, 1};
        int ni, nf, ti, tf;
        sw_num = 4'd3; tick(); tick();
        foreach (pattern[i]) begin
            key_insert_n = pattern[i];
            tick();
            checks++; if (insert_pulse !== 1'b0) begin failures++; $display("FAIL bounce_early: got %b expected 0", insert_pulse); end
        end
        press_keys(1'b1, 1'b0, 20, ni, nf, ti, tf);
        checks++; if (ti !== D + 2) begin failures++; $display("FAIL bounce_latency: got %0d expected %0d", ti, D + 2); end
        checks++; if (ni !== 1) begin failures++; $display("FAIL bounce_count: got %0d expected 1", ni); end
        checks++; if (num_out !== 4'd3) begin failures++; $display("FAIL bounce_num: got %0d expected 3", num_out); end
    endtask

    task automatic test_invalid_digit();
        int ni, nf, ti, tf;
        sw_num = 4'd5; tick(); tick();
        press_keys(1'b1, 1'b0, 10, ni, nf, ti, tf);
        sw_num = 4'd12; tick(); tick();
        press_keys(1'b1, 1'b0, 10, ni, nf, ti, tf);
        checks++; if (ni !== 0) begin failures++; $display("FAIL invalid_pulse: got %0d expected 0", ni); end
        checks++; if (num_invalid !== 1'b1) begin failures++; $display("FAIL invalid_flag: got %b expected 1", num_invalid); end
        checks++; if (num_out !== 4'd5) begin failures++; $display("FAIL invalid_num_kept: got %0d expected 5", num_out); end
        sw_num = 4'd9; tick(); tick();
        press_keys(1'b1, 1'b0, 10, ni, nf, ti, tf);
        checks++; if (ni !== 1) begin failures++; $display("FAIL nine_pulse: got %0d expected 1", ni); end
        checks++; if (num_out !== 4'd9) begin failures++; $display("FAIL nine_num: got %0d expected 9", num_out); end
        checks++; if (num_invalid !== 1'b0) begin failures++; $display("FAIL nine_flag_clear: got %b expected 0", num_invalid); end
    endtask

    task automatic test_simultaneous();
        int ni, nf, ti, tf, waited;
        overlap = 0;
        sw_num = 4'd2; tick(); tick();
        press_keys(1'b1, 1'b1, 20, ni, nf, ti, tf);
        checks++; if (ti !== D + 2) begin failures++; $display("FAIL simul_insert_time: got %0d expected %0d", ti, D + 2); end
        checks++; if (tf !== D + 3) begin failures++; $display("FAIL simul_finish_time: got %0d expected %0d", tf, D + 3); end
        checks++; if (ni !== 1 || nf !== 1) begin failures++; $display("FAIL simul_counts: got %0d/%0d expected 1/1", ni, nf); end
        checks++; if (overlap !== 0) begin failures++; $display("FAIL simul_overlap: got %0d expected 0", overlap); end
        // Reset while the deferred finish is pending must discard it.
        key_insert_n = 1'b0; key_finish_n = 1'b0;
        waited = 0;
        while (!insert_pulse && waited < 20) begin tick(); waited++; end
        checks++; if (insert_pulse !== 1'b1) begin failures++; $display("FAIL pend_insert_seen: got %b expected 1", insert_pulse); end
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if (finish_pulse !== 1'b0) begin failures++; $display("FAIL pend_discard_a: got %b expected 0", finish_pulse); end
        tick();
        checks++; if (finish_pulse !== 1'b0) begin failures++; $display("FAIL pend_discard_b: got %b expected 0", finish_pulse); end
        key_insert_n = 1'b1; key_finish_n = 1'b1;
        repeat (D + 4) tick();
    endtask

    task automatic test_held_through_reset();
        int ni, nf, ti, tf, cnt;
        key_insert_n = 1'b0; sw_num = 4'd4;
        reset = 1'b1; tick(); tick(); reset = 1'b0;
        cnt = 0;
        repeat (20) begin tick(); if (insert_pulse) cnt++; end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL held_no_pulse: got %0d expected 0", cnt); end
        key_insert_n = 1'b1;
        repeat (D) tick();
        press_keys(1'b1, 1'b0, 20, ni, nf, ti, tf);
        checks++; if (ni !== 1 || ti !== D + 2) begin failures++; $display("FAIL held_rearm: got %0d pulses at %0d expected 1 at %0d", ni, ti, D + 2); end
    endtask

    task automatic test_reset_mid_press();
        int ni, nf, ti, tf, cnt;
        sw_num = 4'd6; tick(); tick();
        key_insert_n = 1'b0;
        repeat (3) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        checks++; if ({insert_pulse, finish_pulse, num_out, num_invalid} !== 7'd0) begin
            failures++; $display("FAIL midreset_outputs: got %b expected 0000000", {insert_pulse, finish_pulse, num_out, num_invalid}); end
        cnt = 0;
        repeat (20) begin tick(); if (insert_pulse) cnt++; end
        checks++; if (cnt !== 0) begin failures++; $display("FAIL midreset_no_pulse: got %0d expected 0", cnt); end
        key_insert_n = 1'b1;
        repeat (D + 4) tick();
        press_keys(1'b1, 1'b0, 10, ni, nf, ti, tf);
        checks++; if (ni !== 1 || num_out !== 4'd6) begin failures++; $display("FAIL midreset_recover: got %0d pulses num %0d expected 1 num 6", ni, num_out); end
    endtask

    task automatic test_random();
        int run_i, run_f, shown, pulses;
        reset = 1'b1; key_insert_n = 1'b1; key_finish_n = 1'b1; sw_num = 4'd0;
        tick(); reset = 1'b0;
        run_i = 1; run_f = 1; shown = 0; pulses = 0; overlap = 0;
        for (int c = 0; c < 4000; c++) begin
            if (--run_i == 0) begin key_insert_n = ~key_insert_n; run_i = $urandom_range(1, 2 * D + 3); end
            if (--run_f == 0) begin key_finish_n = ~key_finish_n; run_f = $urandom_range(1, 2 * D + 3); end
            if ($urandom_range(0, 7) == 0) sw_num = 4'($urandom_range(0, 15));
            if (c == 2000) reset = 1'b1;
            if (c == 2001) reset = 1'b0;
            tick();
            if (insert_pulse || finish_pulse) pulses++;
            checks++;
            if ({insert_pulse, finish_pulse, num_out, num_invalid} !== {exp_ins, exp_fin, exp_num, exp_inv}) begin
                failures++;
                if (shown++ < 10) $display("FAIL random_cycle%0d: got ins=%b fin=%b num=%0d inv=%b expected ins=%b fin=%b num=%0d inv=%b",
                    c, insert_pulse, finish_pulse, num_out, num_invalid, exp_ins, exp_fin, exp_num, exp_inv);
            end
        end
        checks++; if (overlap !== 0) begin failures++; $display("FAIL random_overlap: got %0d expected 0", overlap); end
        checks++; if (pulses == 0) begin failures++; $display("FAIL random_activity: got 0 strobes expected >0"); end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_invalid_digit();
        test_simultaneous();
        test_held_through_reset();
        test_reset_mid_press();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
